// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xorn_pkg.sv
// Shared types and helpers for the XOR accumulator: packet state and
// saturating beat-count increment.
package gf180mcu_fd_sc_mcu9t5v0__xorn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Increment val, clamping at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
    return (val >= max_val) ? max_val : (val + 32'h1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xorn_red.sv
// Combinational WIDTH-to-1 XOR reduction; synthesis balances it into a
// log-depth tree of two-input XOR cells.
module gf180mcu_fd_sc_mcu9t5v0__xorn_red #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  assign parity = ^data;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xorn_acc.sv
// Registered per-packet XOR checksum with valid/ready on both sides.
// Define GF180MCU_FD_SC_MCU9T5V0__XORN_ACC_CHECK_EN to compare against in_exp.
module gf180mcu_fd_sc_mcu9t5v0__xorn_acc
  import gf180mcu_fd_sc_mcu9t5v0__xorn_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [WIDTH-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_err
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             first;
  logic [WIDTH-1:0] nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             par_nxt;

  // Ready depends only on the result register, never on in_valid.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state == IDLE);
  assign nxt      = first ? in_data : (acc ^ in_data);
  assign cnt_inc  = CNT_W'(sat_inc(first ? 32'd0 : 32'(cnt), CNT_W));

  gf180mcu_fd_sc_mcu9t5v0__xorn_red #(
    .WIDTH (WIDTH)
  ) u_red (
    .data   (nxt),
    .parity (par_nxt)
  );

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = in_last ? IDLE : ACC;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (in_last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= nxt;
          cnt <= cnt_inc;
        end
      end
    end
  end

  // Result register: a new result may load on the same edge the old one retires.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_parity <= 1'b0;
      out_beats  <= '0;
    end else if (accept && in_last) begin
      out_valid  <= 1'b1;
      out_data   <= nxt;
      out_parity <= par_nxt;
      out_beats  <= cnt_inc;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0__XORN_ACC_CHECK_EN
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      out_err <= 1'b0;
    end else if (accept && in_last) begin
      out_err <= (nxt != in_exp);
    end
  end
`else
  logic unused_exp;
  assign unused_exp = ^in_exp;
  assign out_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__xorn_acc.sv
// Scoreboard bench for the XOR accumulator; a second instance with a 2-bit
// counter shares the stimulus to exercise beat-count saturation.
module tb_gf180mcu_fd_sc_mcu9t5v0__xorn_acc;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] in_exp = 8'h00;

  logic       in_ready, out_valid, out_parity, out_err;
  logic [7:0] out_data, out_beats;
  logic       in_ready2, out_valid2, out_parity2, out_err2;
  logic [7:0] out_data2;
  logic [1:0] out_beats2;

  gf180mcu_fd_sc_mcu9t5v0__xorn_acc #(.WIDTH(8), .CNT_W(8)) dut (
    .CLK(CLK), .RN(RN), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .out_beats(out_beats), .out_err(out_err)
  );

  gf180mcu_fd_sc_mcu9t5v0__xorn_acc #(.WIDTH(8), .CNT_W(2)) dut2 (
    .CLK(CLK), .RN(RN), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_last(in_last), .in_exp(in_exp),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .out_parity(out_parity2), .out_beats(out_beats2), .out_err(out_err2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         beats;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_x;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_acc = 8'h00;
  int         m_cnt = 0;
  bit         m_first = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_first = 1'b1;
    m_acc   = 8'h00;
    m_cnt   = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic send_beat(input logic [7:0] d, input bit last, input logic [7:0] e);
    int         waits;
    logic [7:0] nxt;
    exp_t       x;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_exp   = e;
    #1;
    while (!in_ready) begin
      waits++;
      if (waits > 50) begin
        check_eq("ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        @(negedge CLK);
        return;
      end
      @(negedge CLK);
      out_ready = 1'b1;
      #1;
    end
    nxt = m_first ? d : (m_acc ^ d);
    m_cnt++;
    if (last) begin
      x.data  = nxt;
      x.beats = m_cnt;
`ifdef GF180MCU_FD_SC_MCU9T5V0__XORN_ACC_CHECK_EN
      x.err   = (nxt != e);
`else
      x.err   = 1'b0;
`endif
      sb.push_back(x);
      model_reset();
    end else begin
      m_acc   = nxt;
      m_first = 1'b0;
    end
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // A result retires on the rising edge after a falling-edge sample with valid && ready.
  always @(negedge CLK) begin
    #2;
    if (RN && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_x = sb.pop_front();
        check_eq("out_data", 32'(out_data), 32'(mon_x.data));
        check_eq("out_parity", 32'(out_parity), 32'(^mon_x.data));
        check_eq("out_beats", 32'(out_beats), 32'(sat(mon_x.beats, 8)));
        check_eq("out_err", 32'(out_err), 32'(mon_x.err));
        check_eq("sat_valid", 32'(out_valid2), 32'd1);
        check_eq("sat_data", 32'(out_data2), 32'(mon_x.data));
        check_eq("sat_beats", 32'(out_beats2), 32'(sat(mon_x.beats, 2)));
      end
    end
  end

  initial begin
    logic [7:0] d;
    int         len;

    repeat (2) @(negedge CLK);
    #1;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_parity", 32'(out_parity), 32'd0);
    check_eq("rst_beats", 32'(out_beats), 32'd0);
    check_eq("rst_err", 32'(out_err), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    RN = 1'b1;
    @(negedge CLK);

    // Reset in the middle of a packet discards the partial checksum.
    out_ready = 1'b1;
    send_beat(8'h11, 1'b0, 8'h00);
    send_beat(8'h22, 1'b0, 8'h00);
    RN = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    RN = 1'b1;
    model_reset();
    send_beat(8'h5A, 1'b1, 8'h00);
    check_eq("single_data", 32'(out_data), 32'h5A);

    // Three-beat packet; result appears only after the last beat.
    send_beat(8'h0F, 1'b0, 8'h00);
    send_beat(8'hF0, 1'b0, 8'h00);
    check_eq("no_early_valid", 32'(out_valid), 32'd0);
    send_beat(8'h3C, 1'b1, 8'h00);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("c3_data", 32'(out_data), 32'hC3);
    @(negedge CLK);

    // Backpressure holds the result and blocks the next beat.
    out_ready = 1'b0;
    send_beat(8'h01, 1'b1, 8'h00);
    repeat (4) begin
      in_valid = 1'b1;
      in_data  = 8'h02;
      in_last  = 1'b1;
      #1;
      check_eq("bp_ready", 32'(in_ready), 32'd0);
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_data", 32'(out_data), 32'h01);
      check_eq("bp_beats", 32'(out_beats), 32'd1);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    send_beat(8'h02, 1'b1, 8'h00);
    check_eq("bp_next_data", 32'(out_data), 32'h02);

    // Back-to-back single-beat packets, one result per cycle.
    for (int i = 0; i < 3; i++) begin
      d = 8'((2 << i) - 1);
      send_beat(d, 1'b1, 8'h00);
      check_eq("b2b_valid", 32'(out_valid), 32'd1);
      check_eq("b2b_data", 32'(out_data), 32'(d));
      check_eq("b2b_parity", 32'(out_parity), 32'(^d));
    end

    // Saturation: 5 beats (2-bit counter clamps), then 300 beats (8-bit clamps).
    for (int i = 0; i < 5; i++) send_beat(8'hFF, (i == 4), 8'h00);
    for (int i = 0; i < 300; i++) send_beat(8'hFF, (i == 299), 8'h00);

    // Checksum compare against in_exp.
    send_beat(8'hAA, 1'b0, 8'h00);
    send_beat(8'h55, 1'b1, 8'hFF);
    send_beat(8'hAA, 1'b0, 8'h00);
    send_beat(8'h55, 1'b1, 8'hFE);

    // Random packets with random downstream stalls.
    for (int p = 0; p < 20; p++) begin
      len = int'($urandom_range(1, 6));
      for (int b = 0; b < len; b++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        send_beat(8'($urandom), (b == len - 1), 8'($urandom));
      end
    end

    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    #3;
    check_eq("drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
